// File: rtl/clint_irq_ctrl.sv
// Purpose : holds CLINT MSIP/MTIP pending bits, applies MIE/mstatus.MIE and drives one req/ack/done handshake.
// Latency : set pulse in N -> mip bit in N+1 -> irq_req in N+2; all outputs registered.
// Backpressure: request is held until irq_ack, until the source is no longer eligible, or until the ack timeout.
module clint_irq_ctrl #(
    parameter int          CAUSE_W     = 4,
    parameter int unsigned MSI_CAUSE   = 3,
    parameter int unsigned MTI_CAUSE   = 7,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timer_int,
    input  logic               clear_timer_int,
    input  logic               soft_int,
    input  logic               clear_soft_int,
    input  logic               mie_msie,
    input  logic               mie_mtie,
    input  logic               mstatus_mie,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               irq_req,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic               irq_active,
    output logic               mip_msip,
    output logic               mip_mtip,
    output logic               timeout_err
);

    // Cause codes trimmed to the output width.
    localparam logic [CAUSE_W-1:0] MSI_CODE = MSI_CAUSE[CAUSE_W-1:0];
    localparam logic [CAUSE_W-1:0] MTI_CODE = MTI_CAUSE[CAUSE_W-1:0];

    // Timeout fires when the counter reaches ACK_TIMEOUT-1 (counter is 0 in the first REQ cycle),
    // so the request is visible for exactly ACK_TIMEOUT cycles. ACK_TIMEOUT==0 disables it.
    localparam bit         TO_EN   = (ACK_TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = (ACK_TIMEOUT > 0) ? 8'(ACK_TIMEOUT - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    typedef enum logic {
        SRC_MSI = 1'b0,
        SRC_MTI = 1'b1
    } src_t;

    state_t             state_q;
    src_t               sel_src_q;
    logic [7:0]         cnt_q;
    logic               irq_req_q;
    logic               irq_active_q;
    logic [CAUSE_W-1:0] irq_cause_q;
    logic               timeout_err_q;

    logic               msip_q, msip_d;
    logic               mtip_q, mtip_d;

    logic               elig_s;
    logic               elig_t;
    logic               sel_elig;
    logic               to_hit;

    // Pending bit next state: a set pulse wins over a simultaneous clear.
    always_comb begin
        msip_d = soft_int  | (msip_q & ~clear_soft_int);
        mtip_d = timer_int | (mtip_q & ~clear_timer_int);
    end

    // Pending bits live independently of enables and of the handshake state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_q <= 1'b0;
            mtip_q <= 1'b0;
        end else begin
            msip_q <= msip_d;
            mtip_q <= mtip_d;
        end
    end

    // Eligibility from registered pending bits, eligibility of the latched source, timeout compare.
    always_comb begin
        elig_s   = msip_q & mie_msie & mstatus_mie;
        elig_t   = mtip_q & mie_mtie & mstatus_mie;
        sel_elig = (sel_src_q == SRC_MSI) ? elig_s : elig_t;
        to_hit   = TO_EN && (cnt_q == TO_LAST);
    end

    // Handshake FSM with registered outputs; arbitration happens only when leaving IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_src_q     <= SRC_MSI;
            cnt_q         <= 8'd0;
            irq_req_q     <= 1'b0;
            irq_active_q  <= 1'b0;
            irq_cause_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (elig_s || elig_t) begin
                        // Software outranks timer (MSI > MTI).
                        state_q     <= ST_REQ;
                        irq_req_q   <= 1'b1;
                        cnt_q       <= 8'd0;
                        sel_src_q   <= elig_s ? SRC_MSI : SRC_MTI;
                        irq_cause_q <= elig_s ? MSI_CODE : MTI_CODE;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        // Ack beats withdraw and timeout in the same cycle.
                        state_q      <= ST_SERVICE;
                        irq_req_q    <= 1'b0;
                        irq_active_q <= 1'b1;
                    end else if (!sel_elig) begin
                        state_q     <= ST_IDLE;
                        irq_req_q   <= 1'b0;
                        irq_cause_q <= '0;
                    end else if (to_hit) begin
                        state_q       <= ST_IDLE;
                        irq_req_q     <= 1'b0;
                        irq_cause_q   <= '0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_SERVICE: begin
                    // Pending bits are left alone; software clears them through the CLINT.
                    if (irq_done) begin
                        state_q      <= ST_IDLE;
                        irq_active_q <= 1'b0;
                        irq_cause_q  <= '0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    irq_req_q    <= 1'b0;
                    irq_active_q <= 1'b0;
                    irq_cause_q  <= '0;
                end
            endcase
        end
    end

    // A request and an active handler are never presented together.
    a_req_act_excl: assert property (@(posedge clk) disable iff (rst) !(irq_req_q && irq_active_q));

    assign irq_req     = irq_req_q;
    assign irq_cause   = irq_cause_q;
    assign irq_active  = irq_active_q;
    assign mip_msip    = msip_q;
    assign mip_mtip    = mtip_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_clint_irq_ctrl.sv
// Purpose : checks clint_irq_ctrl with directed vectors, a timeout sequence and random stimulus.
// Latency : one clock per applied vector; outputs sampled 1 time unit after the rising edge.
// Backpressure: none; the bench drives irq_ack/irq_done directly.
module tb_clint_irq_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          timer_int, clear_timer_int, soft_int, clear_soft_int;
    logic          mie_msie, mie_mtie, mstatus_mie;
    logic          irq_ack, irq_done;
    logic          irq_req;
    logic [CW-1:0] irq_cause;
    logic          irq_active;
    logic          mip_msip, mip_mtip;
    logic          timeout_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clint_irq_ctrl #(
        .CAUSE_W    (CW),
        .MSI_CAUSE  (3),
        .MTI_CAUSE  (7),
        .ACK_TIMEOUT(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .timer_int      (timer_int),
        .clear_timer_int(clear_timer_int),
        .soft_int       (soft_int),
        .clear_soft_int (clear_soft_int),
        .mie_msie       (mie_msie),
        .mie_mtie       (mie_mtie),
        .mstatus_mie    (mstatus_mie),
        .irq_ack        (irq_ack),
        .irq_done       (irq_done),
        .irq_req        (irq_req),
        .irq_cause      (irq_cause),
        .irq_active     (irq_active),
        .mip_msip       (mip_msip),
        .mip_mtip       (mip_mtip),
        .timeout_err    (timeout_err)
    );

    // Input bit positions: {rst, ti, cti, si, csi, msie, mtie, gmie, ack, done}
    localparam logic [9:0] RST  = 10'b10_0000_0000;
    localparam logic [9:0] TI   = 10'b01_0000_0000;
    localparam logic [9:0] CTI  = 10'b00_1000_0000;
    localparam logic [9:0] SI   = 10'b00_0100_0000;
    localparam logic [9:0] CSI  = 10'b00_0010_0000;
    localparam logic [9:0] MSIE = 10'b00_0001_0000;
    localparam logic [9:0] MTIE = 10'b00_0000_1000;
    localparam logic [9:0] GMIE = 10'b00_0000_0100;
    localparam logic [9:0] ACK  = 10'b00_0000_0010;
    localparam logic [9:0] DONE = 10'b00_0000_0001;
    localparam logic [9:0] EN   = MSIE | MTIE | GMIE;

    typedef struct packed {
        logic [9:0] in;
        logic [8:0] exp;   // {req, cause[3:0], active, msip, mtip, terr}
    } vec_t;

    // Expected output bundle.
    function automatic logic [8:0] o(input bit req, input int cause, input bit act,
                                     input bit msip, input bit mtip, input bit terr);
        return {req, 4'(cause), act, msip, mtip, terr};
    endfunction

    task automatic drive(input logic [9:0] in);
        {rst, timer_int, clear_timer_int, soft_int, clear_soft_int,
         mie_msie, mie_mtie, mstatus_mie, irq_ack, irq_done} = in;
    endtask

    // Apply one vector across a rising edge and compare just after it.
    task automatic apply(input string name, input logic [9:0] in, input logic [8:0] exp);
        logic [8:0] act;
        drive(in);
        @(posedge clk);
        #1;
        act = {irq_req, irq_cause, irq_active, mip_msip, mip_mtip, timeout_err};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got req=%b cause=%0d act=%b msip=%b mtip=%b terr=%b, want req=%b cause=%0d act=%b msip=%b mtip=%b terr=%b",
                     name, act[8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Behavioural reference: phase 0 = nothing presented, 1 = presenting, 2 = handler running.
    // m_age counts how many cycles the current request has been visible.
    bit m_msip, m_mtip, m_terr;
    int m_phase, m_cause, m_age;

    task automatic model_step(input logic [9:0] in);
        bit r, ti, cti, si, csi, msie, mtie, gmie, ack, done;
        bit es, et, still_ok;
        {r, ti, cti, si, csi, msie, mtie, gmie, ack, done} = in;
        if (r) begin
            m_msip = 0; m_mtip = 0; m_terr = 0; m_phase = 0; m_cause = 0; m_age = 0;
            return;
        end
        es = m_msip && msie && gmie;
        et = m_mtip && mtie && gmie;
        m_terr = 0;
        if (m_phase == 0) begin
            if (es || et) begin
                m_phase = 1;
                m_cause = es ? 3 : 7;
                m_age   = 1;
            end
        end else if (m_phase == 1) begin
            still_ok = (m_cause == 3) ? es : et;
            if (ack)                m_phase = 2;
            else if (!still_ok)     m_phase = 0;
            else if (m_age == 4) begin
                m_phase = 0;
                m_terr  = 1;
            end else                m_age = m_age + 1;
        end else begin
            if (done) m_phase = 0;
        end
        m_msip = si || (m_msip && !csi);
        m_mtip = ti || (m_mtip && !cti);
    endtask

    function automatic logic [8:0] model_out();
        return o(m_phase == 1, (m_phase == 0) ? 0 : m_cause, m_phase == 2, m_msip, m_mtip, m_terr);
    endfunction

    vec_t tbl[31];

    initial begin
        // Reset, then basic software request / ack / done.
        tbl[0]  = '{in: RST | EN,       exp: o(0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{in: SI | EN,        exp: o(0, 0, 0, 1, 0, 0)};
        tbl[2]  = '{in: EN,             exp: o(1, 3, 0, 1, 0, 0)};
        tbl[3]  = '{in: EN,             exp: o(1, 3, 0, 1, 0, 0)};
        tbl[4]  = '{in: EN | ACK,       exp: o(0, 3, 1, 1, 0, 0)};
        tbl[5]  = '{in: EN | ACK,       exp: o(0, 3, 1, 1, 0, 0)};
        tbl[6]  = '{in: EN | CSI,       exp: o(0, 3, 1, 0, 0, 0)};
        tbl[7]  = '{in: EN | DONE,      exp: o(0, 0, 0, 0, 0, 0)};
        // Both sources together: software first, then timer.
        tbl[8]  = '{in: EN | SI | TI,   exp: o(0, 0, 0, 1, 1, 0)};
        tbl[9]  = '{in: EN,             exp: o(1, 3, 0, 1, 1, 0)};
        tbl[10] = '{in: EN | ACK,       exp: o(0, 3, 1, 1, 1, 0)};
        tbl[11] = '{in: EN | CSI,       exp: o(0, 3, 1, 0, 1, 0)};
        tbl[12] = '{in: EN | DONE,      exp: o(0, 0, 0, 0, 1, 0)};
        tbl[13] = '{in: EN,             exp: o(1, 7, 0, 0, 1, 0)};
        tbl[14] = '{in: EN | ACK,       exp: o(0, 7, 1, 0, 1, 0)};
        tbl[15] = '{in: EN | CTI,       exp: o(0, 7, 1, 0, 0, 0)};
        tbl[16] = '{in: EN | DONE,      exp: o(0, 0, 0, 0, 0, 0)};
        // Set and clear together (set wins), then withdrawal by clear in REQ.
        tbl[17] = '{in: EN | TI | CTI,  exp: o(0, 0, 0, 0, 1, 0)};
        tbl[18] = '{in: EN,             exp: o(1, 7, 0, 0, 1, 0)};
        tbl[19] = '{in: EN | CTI,       exp: o(1, 7, 0, 0, 0, 0)};
        tbl[20] = '{in: EN,             exp: o(0, 0, 0, 0, 0, 0)};
        // Global enable gating, enable drop withdraws, no re-arbitration in REQ.
        tbl[21] = '{in: MSIE | MTIE | SI, exp: o(0, 0, 0, 1, 0, 0)};
        tbl[22] = '{in: MSIE | MTIE,    exp: o(0, 0, 0, 1, 0, 0)};
        tbl[23] = '{in: MSIE | MTIE | TI, exp: o(0, 0, 0, 1, 1, 0)};
        tbl[24] = '{in: EN,             exp: o(1, 3, 0, 1, 1, 0)};
        tbl[25] = '{in: MSIE | MTIE,    exp: o(0, 0, 0, 1, 1, 0)};
        tbl[26] = '{in: MTIE | GMIE,    exp: o(1, 7, 0, 1, 1, 0)};
        tbl[27] = '{in: EN | ACK,       exp: o(0, 7, 1, 1, 1, 0)};
        // Reset during SERVICE wipes everything.
        tbl[28] = '{in: RST | EN,       exp: o(0, 0, 0, 0, 0, 0)};
        tbl[29] = '{in: EN,             exp: o(0, 0, 0, 0, 0, 0)};
        tbl[30] = '{in: EN,             exp: o(0, 0, 0, 0, 0, 0)};

        drive(RST);
        #1;
        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);

        // Ack timeout of 4 cycles: req visible 4 cycles, err pulse, req returns next cycle.
        apply("to_set", EN | SI, o(0, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 4; k++) apply($sformatf("to_req%0d", k), EN, o(1, 3, 0, 1, 0, 0));
        apply("to_err", EN, o(0, 0, 0, 1, 0, 1));
        for (int k = 1; k <= 4; k++) apply($sformatf("to_rereq%0d", k), EN, o(1, 3, 0, 1, 0, 0));
        // Ack arriving in the timeout cycle wins.
        apply("to_ack_wins", EN | ACK, o(0, 3, 1, 1, 0, 0));
        apply("to_done", EN | CSI | DONE, o(0, 0, 0, 0, 0, 0));

        // Randomized run against the reference model.
        apply("rnd_rst", RST | EN, o(0, 0, 0, 0, 0, 0));
        model_step(RST);
        for (int c = 0; c < 3000; c++) begin
            logic [9:0] in;
            in = '0;
            if ($urandom_range(0, 255) == 0) in |= RST;
            if ($urandom_range(0, 7) == 0)   in |= TI;
            if ($urandom_range(0, 7) == 0)   in |= CTI;
            if ($urandom_range(0, 7) == 0)   in |= SI;
            if ($urandom_range(0, 7) == 0)   in |= CSI;
            if ($urandom_range(0, 7) != 0)   in |= MSIE;
            if ($urandom_range(0, 7) != 0)   in |= MTIE;
            if ($urandom_range(0, 9) != 0)   in |= GMIE;
            if ($urandom_range(0, 3) == 0)   in |= ACK;
            if ($urandom_range(0, 3) == 0)   in |= DONE;
            model_step(in);
            apply($sformatf("rnd%0d", c), in, model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
